// File: rtl/normalize_shift_pipe.sv
// normalize_shift_pipe: two-stage left-normalization shifter.
// Stage 1 applies the coarse (multiple-of-8) shift. Stage 2 applies the fine
// 0..7 bit shift, compensates the exponent and resolves the zero/underflow flags.
// Both stages use a valid/ready handshake, so the pipeline can stall without
// dropping beats.
module normalize_shift_pipe #(
    parameter int W  = 55,
    parameter int EW = 11,
    parameter int SW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [W-1:0]  mant_i,
    input  logic [SW-1:0] shift_i,
    input  logic [EW-1:0] exp_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [W-1:0]  mant_o,
    output logic [EW-1:0] exp_o,
    output logic          zero_o,
    output logic          unf_o
);

    localparam logic [SW-1:0] WLIM = SW'(W);

    // Stage 1 registers
    logic          s1_v;
    logic [W-1:0]  s1_mant;
    logic [2:0]    s1_fine;
    logic [EW-1:0] s1_exp;
    logic [SW-1:0] s1_shift;
    logic          s1_range;
    logic          s1_zero;

    // Stage 2 valid; its data registers are the outputs themselves
    logic          s2_v;

    logic          adv1;
    logic          adv2;

    // Stage 2 combinational results
    logic [W-1:0]  fine_mant;
    logic [EW:0]   exp_diff;
    logic          kill;
    logic          under;

    // Handshake: a stage advances when it is empty or its consumer advances
    always_comb begin
        adv2       = ~s2_v | out_ready_i;
        adv1       = ~s1_v | adv2;
        in_ready_o = adv1;
    end

    // Fine shift, exponent compensation and flag priority (zero/range over underflow)
    always_comb begin
        fine_mant = s1_mant << s1_fine;
        exp_diff  = {1'b0, s1_exp} - {{(EW + 1 - SW){1'b0}}, s1_shift};
        kill      = s1_zero | s1_range;
        under     = ~kill & exp_diff[EW];
    end

    // Stage 1: coarse shift by shift_i[SW-1:3]*8, capture side information
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_mant  <= '0;
            s1_fine  <= '0;
            s1_exp   <= '0;
            s1_shift <= '0;
            s1_range <= 1'b0;
            s1_zero  <= 1'b0;
        end else if (adv1) begin
            s1_v     <= in_valid_i;
            s1_mant  <= mant_i << {shift_i[SW-1:3], 3'b000};
            s1_fine  <= shift_i[2:0];
            s1_exp   <= exp_i;
            s1_shift <= shift_i;
            s1_range <= (shift_i >= WLIM);
            s1_zero  <= (mant_i == '0);
        end
    end

    // Stage 2: register normalized result and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v   <= 1'b0;
            mant_o <= '0;
            exp_o  <= '0;
            zero_o <= 1'b0;
            unf_o  <= 1'b0;
        end else if (adv2) begin
            s2_v   <= s1_v;
            mant_o <= kill ? '0 : fine_mant;
            exp_o  <= (kill | under) ? '0 : exp_diff[EW-1:0];
            zero_o <= kill;
            unf_o  <= under;
        end
    end

    assign out_valid_o = s2_v;

endmodule

// File: tb/tb_normalize_shift_pipe.sv
// Testbench for normalize_shift_pipe: directed steps plus a scoreboard that
// predicts each accepted beat and checks it when it appears at the output.
module tb_normalize_shift_pipe;

    localparam int W  = 55;
    localparam int EW = 11;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [W-1:0]  mant_i;
    logic [SW-1:0] shift_i;
    logic [EW-1:0] exp_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  mant_o;
    logic [EW-1:0] exp_o;
    logic          zero_o;
    logic          unf_o;

    typedef struct packed {
        logic [W-1:0]  m;
        logic [EW-1:0] e;
        logic          z;
        logic          u;
    } res_t;

    res_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   nout     = 0;

    normalize_shift_pipe #(.W(W), .EW(EW), .SW(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mant_i      (mant_i),
        .shift_i     (shift_i),
        .exp_i       (exp_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .mant_o      (mant_o),
        .exp_o       (exp_o),
        .zero_o      (zero_o),
        .unf_o       (unf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: full shift, exponent minus shift, zero/range dominate underflow
    function automatic res_t model(input logic [W-1:0] m, input int sh, input int e);
        res_t r;
        logic [W-1:0] t;
        r = '0;
        if (m == 0 || sh >= W) begin
            r.z = 1'b1;
        end else begin
            t = m;
            for (int k = 0; k < sh; k++) t = {t[W-2:0], 1'b0};
            r.m = t;
            if (sh > e) r.u = 1'b1;
            else        r.e = EW'(e - sh);
        end
        return r;
    endfunction

    // Scoreboard: compare the presented beat with the oldest prediction (also
    // checks stability while stalled), pop on output transfer, push on input transfer
    always @(negedge clk) begin
        res_t h;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", {63'b0, out_valid_o}, 64'd0);
                end else begin
                    chk("sb_mant", {9'b0, mant_o}, {9'b0, q[0].m});
                    chk("sb_exp", {53'b0, exp_o}, {53'b0, q[0].e});
                    chk("sb_zero", {63'b0, zero_o}, {63'b0, q[0].z});
                    chk("sb_unf", {63'b0, unf_o}, {63'b0, q[0].u});
                    if (out_ready_i) begin
                        h = q.pop_front();
                        nout++;
                    end
                end
            end
            if (in_valid_i && in_ready_o)
                q.push_back(model(mant_i, int'(shift_i), int'(exp_i)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] m, input int sh, input int e);
        in_valid_i = 1'b1;
        mant_i     = m;
        shift_i    = SW'(sh);
        exp_i      = EW'(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && q.size() != 0; k++) step();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int base;
        int acc;
        logic [63:0] rnd;

        rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
        mant_i = '0; shift_i = '0; exp_i = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", {63'b0, out_valid_o}, 64'd0);
        chk("rst_ready", {63'b0, in_ready_o}, 64'd1);
        chk("rst_mant", {9'b0, mant_o}, 64'd0);
        chk("rst_exp", {53'b0, exp_o}, 64'd0);
        chk("rst_flags", {62'b0, zero_o, unf_o}, 64'd0);

        // Basic normalize with explicit 2-cycle latency
        drive(55'h1, 54, 100);
        step();
        in_valid_i = 1'b0;
        chk("lat_not_yet", {63'b0, out_valid_o}, 64'd0);
        step();
        chk("lat_valid", {63'b0, out_valid_o}, 64'd1);
        chk("basic_mant", {9'b0, mant_o}, 64'h0040_0000_0000_0000);
        chk("basic_exp", {53'b0, exp_o}, 64'd46);
        step();

        // Zero, range, underflow, shift==exp, back-to-back
        drive(55'h0, 0, 77);  step();
        drive(55'h1, 60, 200); step();
        drive(55'h1, 54, 10); step();
        drive(55'h3, 5, 5);   step();
        drive(55'h7f, 55, 300); step();
        in_valid_i = 1'b0;
        drain();

        // Stall: 5 beats, out_ready low for the first 4 cycles
        base = nout;
        acc  = 0;
        for (int cyc = 0; cyc < 20 && acc < 5; cyc++) begin
            out_ready_i = (cyc >= 4);
            drive(55'h1234_5678 + 55'(acc), acc, 40);
            #1;
            if (cyc == 2 || cyc == 3) begin
                chk("stall_ready_low", {63'b0, in_ready_o}, 64'd0);
                chk("stall_acc", 64'(acc), 64'd2);
            end
            if (in_ready_o) acc++;
            @(posedge clk); #1;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        drain();
        chk("stall_count", 64'(nout - base), 64'd5);

        // Full throughput with random beats
        base = nout;
        for (int i = 0; i < 100; i++) begin
            rnd = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       rnd = 64'd0;
                1:       rnd = 64'($urandom_range(1, 255));
                default: ;
            endcase
            drive(rnd[W-1:0], int'($urandom_range(0, 63)), int'($urandom_range(0, 2047)));
            if (i >= 2) chk("tput_valid", {63'b0, out_valid_o}, 64'd1);
            step();
        end
        in_valid_i = 1'b0;
        step(); step();
        chk("tput_count", 64'(nout - base), 64'd100);
        drain();

        // Reset mid-stream with both stages full
        out_ready_i = 1'b0;
        drive(55'h55, 3, 20); step();
        drive(55'h66, 4, 20); step();
        chk("full_ready_low", {63'b0, in_ready_o}, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid_i = 1'b0;
        chk("mrst_valid", {63'b0, out_valid_o}, 64'd0);
        chk("mrst_ready", {63'b0, in_ready_o}, 64'd1);
        chk("mrst_outs", {zero_o, unf_o, 53'b0, exp_o}, 64'd0);
        chk("mrst_mant", {9'b0, mant_o}, 64'd0);
        out_ready_i = 1'b1;
        base = nout;
        for (int k = 0; k < 6; k++) step();
        chk("mrst_no_ghost", 64'(nout - base), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
